nn_mlp_core: RTL and testbench
==============================

// Module: nn_mlp_core
// PURPOSE
// - Fixed-topology MLP inference engine: 2 inputs -> 3 hidden neurons (ReLU) -> 2 outputs (linear).
// - Runs 4 samples per start; signed Q4.12 arithmetic throughout.
// - Host loads weights/biases (WB) and inputs (K) via 64-bit write ports with byte enables.
// - Host reads results from output memory (A); sits behind an AXI/BRAM-style host bridge.
// PARAMETERS
// - DATA_W  16  element width (fixed; other values unsupported)
// - FRAC_W  12  fractional bits of Q4.12 format
// PORTS
// clk       in   1   clock; all logic rising-edge
// rst       in   1   reset; one clock, synchronous, active-high
// en        in   1   compute enable; low freezes FSM/datapath (host ports unaffected)
// clr       in   1   sync clear: abort run, zero A memory
// ready     out  1   high when FSM in IDLE
// start     in   1   run request, sampled when ready&en
// done      out  1   one-cycle pulse at run completion
// wb_ena    in   1   WB port enable
// wb_addra  in   3   WB row (0-7)
// wb_dina   in   64  WB write data
// wb_wea    in   8   WB byte write enables; byte b -> bits [8b+7:8b]
// k_ena     in   1   K port enable
// k_addra   in   2   K row (0-3)
// k_dina    in   64  K write data
// k_wea     in   8   K byte write enables
// a_enb     in   1   A read enable
// a_addrb   in   2   A row = sample index
// a_doutb   out  64  A read data, registered, 1-cycle latency; holds when a_enb=0
// BEHAVIOUR
// - Reset: FSM IDLE, ready=1, done=0, a_doutb=0; WB, K, A all cleared to 0.
// - WB/K writes: on edge with ena=1, per-byte wea; accepted anytime, even while busy.
//   Datapath reads current contents combinationally.
// - WB rows 0-2, hidden j: [15:0]=w_x0, [31:16]=w_x1, [47:32]=bias, [63:48] unused.
// - WB rows 3-4, output m: [15:0]=w_h0, [31:16]=w_h1, [47:32]=w_h2, [63:48]=bias.
// - WB rows 5-7 unused.
// - K row i (i=0,1) = feature x_i; sample s in bits [16s+15:16s]. K rows 2-3 unused.
// - A row s: [15:0]=y0, [31:16]=y1, [63:32]=0.
// - Neuron math:
//   - acc = sum(w*x) of 32-bit signed products + (bias <<< 12), 35-bit signed.
//   - r = acc >>> 12 (arithmetic, floor).
//   - r narrowed to 16 bits, then ReLU for hidden (negative -> 0); outputs linear.
// - FSM: IDLE -> per sample s=0..3: H0,H1,H2 (one hidden neuron/cycle), O0,O1, WR (write A[s])
//   -> DONE -> IDLE.
// - Latency: start sampled at edge N; first write at edge N+6; done=1 in the cycle after
//   edge N+24 (DONE state).
// - ready=0 from edge N until DONE exits; ready=1 again the cycle after done.
// - Host ports: start ignored unless ready=1 and en=1; start while busy ignored.
// - en=0 mid-run: state, counters and partial results hold; resumes seamlessly; done delayed
//   by the number of stalled cycles.
// - clr=1: next edge FSM->IDLE, A zeroed, no done pulse; WB/K kept.
// - clr overrides start and en. rst overrides all.
// - A read during run returns current stored content (old or newly written rows).
// CONFIGURATION
// - NN_SATURATE_EN defined: narrowing clamps r to [0x8000,0x7FFF].
// - NN_SATURATE_EN undefined: narrowing keeps r[15:0] (wrap).
// TESTING
// - All WB zero, WB row3 bias=0x0800, any K, start -> done after 25 cycles;
//   every A row = 64'h0000_0000_0000_0800.
// - Row0 w_x0=0x1000, row3 w_h0=0x1000, K0={0x2000,0x2000,0x1400,0x1400} (s3..s0)
//   -> A[s].y0 = 0x1400,0x1400,0x2000,0x2000 for s=0..3; y1=0.
// - Row0 w_x0=0xF000, row3 w_h0=0x1000, K0 all 0x2000 -> hidden clipped by ReLU -> all y0=0.
// - Row0 w_x0=0x7FFF, K0 all 0x7FFF, row3 w_h0=0x1000 -> y0=0x7FFF with NN_SATURATE_EN;
//   y0=0x0000 without (wrap gives 0xFFF0, ReLU -> 0).
// - en=0 for 5 cycles mid-run -> done at 30 cycles, same A as unstalled.
// - clr at cycle 10 -> ready=1 next cycle, no done, all A rows 0; rst mid-run -> reset state.

Source files
------------

// File: rtl/nn_mlp_core.sv
// nn_mlp_core: 2-3-2 MLP inference engine (ReLU hidden layer, linear output layer).
// Signed Q4.12 arithmetic. Each run processes the 4 samples held in the K memory.
// Host-side writes to WB/K are accepted at any time. Results are read from A through a
// registered port with 1-cycle latency.
// Optional feature macro: NN_SATURATE_EN. When defined, neuron results are clamped to
// the 16-bit signed range. When undefined, they wrap.
module nn_mlp_core #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  output logic        ready,
  input  logic        start,
  output logic        done,
  input  logic        wb_ena,
  input  logic [2:0]  wb_addra,
  input  logic [63:0] wb_dina,
  input  logic [7:0]  wb_wea,
  input  logic        k_ena,
  input  logic [1:0]  k_addra,
  input  logic [63:0] k_dina,
  input  logic [7:0]  k_wea,
  input  logic        a_enb,
  input  logic [1:0]  a_addrb,
  output logic [63:0] a_doutb
);

  typedef enum logic [2:0] {
    S_IDLE, S_H0, S_H1, S_H2, S_O0, S_O1, S_WR, S_DONE
  } state_t;

  state_t r_state, w_next;

  // Only WB rows 0-4 and K rows 0-1 carry data; writes to unused rows are dropped.
  logic [63:0] r_wb [0:4];
  logic [63:0] r_k  [0:1];
  logic [31:0] r_a  [0:3];
  logic [31:0] r_dout;

  logic [1:0]               r_sample;
  logic signed [DATA_W-1:0] r_h0, r_h1, r_h2, r_y0, r_y1;

  logic [2:0]         w_row_idx;
  logic [63:0]        w_row;
  logic signed [15:0] w_w0, w_x0, w_w1, w_x1, w_w2, w_x2, w_b;
  logic               w_relu;
  logic [15:0]        w_neuron;

  // One neuron: sum of products plus scaled bias, floor shift back to Q4.12, narrow, ReLU.
  function automatic logic [15:0] neuron(
    input logic signed [15:0] w0, input logic signed [15:0] x0,
    input logic signed [15:0] w1, input logic signed [15:0] x1,
    input logic signed [15:0] w2, input logic signed [15:0] x2,
    input logic signed [15:0] b,  input logic relu);
    logic signed [34:0] acc;
    logic signed [22:0] r;
    logic [15:0]        n;
    acc = 35'(w0) * 35'(x0) + 35'(w1) * 35'(x1) + 35'(w2) * 35'(x2) + (35'(b) <<< FRAC_W);
    r   = acc[34:FRAC_W];
`ifdef NN_SATURATE_EN
    if (r > 23'sh007FFF) begin
      n = 16'h7FFF;
    end else if (r < 23'sh7F8000) begin
      n = 16'h8000;
    end else begin
      n = r[15:0];
    end
`else
    n = r[15:0];
`endif
    if (relu && n[15]) begin
      neuron = 16'h0000;
    end else begin
      neuron = n;
    end
  endfunction

  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);
  assign a_doutb = {32'h0000_0000, r_dout};

  // Select which WB row feeds the neuron evaluated in the current state.
  always_comb begin
    w_row_idx = 3'd0;
    case (r_state)
      S_H0:    w_row_idx = 3'd0;
      S_H1:    w_row_idx = 3'd1;
      S_H2:    w_row_idx = 3'd2;
      S_O0:    w_row_idx = 3'd3;
      S_O1:    w_row_idx = 3'd4;
      default: w_row_idx = 3'd0;
    endcase
  end

  assign w_row = r_wb[w_row_idx];

  // Operand routing: hidden neurons take the current sample's features, outputs take hidden results.
  always_comb begin
    w_w0 = $signed(w_row[15:0]);
    w_w1 = $signed(w_row[31:16]);
    w_w2 = 16'sh0000;
    w_x0 = 16'sh0000;
    w_x1 = 16'sh0000;
    w_x2 = 16'sh0000;
    w_b  = 16'sh0000;
    w_relu = 1'b0;
    if ((r_state == S_O0) || (r_state == S_O1)) begin
      w_w2 = $signed(w_row[47:32]);
      w_x0 = r_h0;
      w_x1 = r_h1;
      w_x2 = r_h2;
      w_b  = $signed(w_row[63:48]);
      w_relu = 1'b0;
    end else begin
      w_x0 = $signed(r_k[0][{r_sample, 4'b0000} +: 16]);
      w_x1 = $signed(r_k[1][{r_sample, 4'b0000} +: 16]);
      w_b  = $signed(w_row[47:32]);
      w_relu = 1'b1;
    end
    w_neuron = neuron(w_w0, w_x0, w_w1, w_x1, w_w2, w_x2, w_b, w_relu);
  end

  // Next-state logic: clr aborts to IDLE, en low freezes the sequence.
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = S_IDLE;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) w_next = S_H0;
          else       w_next = S_IDLE;
        end
        S_H0: w_next = S_H1;
        S_H1: w_next = S_H2;
        S_H2: w_next = S_O0;
        S_O0: w_next = S_O1;
        S_O1: w_next = S_WR;
        S_WR: begin
          if (r_sample == 2'd3) w_next = S_DONE;
          else                  w_next = S_H0;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: capture neuron results, write A[s] and step the sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= 2'd0;
      r_h0 <= 16'sh0000; r_h1 <= 16'sh0000; r_h2 <= 16'sh0000;
      r_y0 <= 16'sh0000; r_y1 <= 16'sh0000;
      for (int i = 0; i < 4; i++) r_a[i] <= 32'h0000_0000;
    end else if (clr) begin
      r_sample <= 2'd0;
      for (int i = 0; i < 4; i++) r_a[i] <= 32'h0000_0000;
    end else if (en) begin
      case (r_state)
        S_IDLE: r_sample <= 2'd0;
        S_H0:   r_h0 <= w_neuron;
        S_H1:   r_h1 <= w_neuron;
        S_H2:   r_h2 <= w_neuron;
        S_O0:   r_y0 <= w_neuron;
        S_O1:   r_y1 <= w_neuron;
        S_WR: begin
          r_a[r_sample] <= {r_y1, r_y0};
          r_sample      <= r_sample + 2'd1;
        end
        default: r_sample <= r_sample;
      endcase
    end
  end

  // Host byte-enabled writes into WB and K, independent of the compute FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) r_wb[i] <= 64'h0;
      for (int i = 0; i < 2; i++) r_k[i]  <= 64'h0;
    end else begin
      if (wb_ena && (wb_addra <= 3'd4)) begin
        for (int b = 0; b < 8; b++) begin
          if (wb_wea[b]) r_wb[wb_addra][8*b +: 8] <= wb_dina[8*b +: 8];
        end
      end
      if (k_ena && !k_addra[1]) begin
        for (int b = 0; b < 8; b++) begin
          if (k_wea[b]) r_k[k_addra[0]][8*b +: 8] <= k_dina[8*b +: 8];
        end
      end
    end
  end

  // Registered A read port; holds its value while a_enb is low.
  always_ff @(posedge clk) begin
    if (rst)        r_dout <= 32'h0000_0000;
    else if (a_enb) r_dout <= r_a[a_addrb];
    else            r_dout <= r_dout;
  end

endmodule

// File: tb/tb_nn_mlp_core.sv
// Directed self-checking bench for nn_mlp_core.
module tb_nn_mlp_core;
  logic        clk = 1'b0;
  logic        rst, en, clr, start;
  logic        wb_ena, k_ena, a_enb;
  logic [2:0]  wb_addra;
  logic [1:0]  k_addra, a_addrb;
  logic [63:0] wb_dina, k_dina;
  logic [7:0]  wb_wea, k_wea;
  logic        ready, done;
  logic [63:0] a_doutb;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int dcount;
  logic [63:0] rd;
  logic [63:0] exp_t4;

  nn_mlp_core dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ready(ready), .start(start), .done(done),
    .wb_ena(wb_ena), .wb_addra(wb_addra), .wb_dina(wb_dina), .wb_wea(wb_wea),
    .k_ena(k_ena), .k_addra(k_addra), .k_dina(k_dina), .k_wea(k_wea),
    .a_enb(a_enb), .a_addrb(a_addrb), .a_doutb(a_doutb)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_wr(input logic [2:0] row, input logic [63:0] d, input logic [7:0] be);
    wb_ena = 1'b1; wb_addra = row; wb_dina = d; wb_wea = be;
    tick();
    wb_ena = 1'b0; wb_wea = 8'h00;
  endtask

  task automatic k_wr(input logic [1:0] row, input logic [63:0] d, input logic [7:0] be);
    k_ena = 1'b1; k_addra = row; k_dina = d; k_wea = be;
    tick();
    k_ena = 1'b0; k_wea = 8'h00;
  endtask

  task automatic a_rd(input logic [1:0] row, output logic [63:0] d);
    a_enb = 1'b1; a_addrb = row;
    tick();
    d = a_doutb;
    a_enb = 1'b0;
  endtask

  task automatic check_rows(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] d;
    a_rd(2'd0, d); check({tag, "_a0"}, d, e0);
    a_rd(2'd1, d); check({tag, "_a1"}, d, e1);
    a_rd(2'd2, d); check({tag, "_a2"}, d, e2);
    a_rd(2'd3, d); check({tag, "_a3"}, d, e3);
  endtask

  // Start a run, optionally stall en for 5 edges from edge stall_at, return edges until done.
  task automatic run(input string tag, input int stall_at, output int l);
    l = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_ready_low"}, {63'd0, ready}, 64'd0);
    for (int i = 1; i <= 120 && l < 0; i++) begin
      en    = !((stall_at != 0) && (i >= stall_at) && (i < stall_at + 5));
      start = (i == 3);
      tick();
      if (done) l = i;
    end
    en = 1'b1;
    start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; start = 1'b0;
    wb_ena = 1'b0; wb_addra = 3'd0; wb_dina = 64'h0; wb_wea = 8'h00;
    k_ena = 1'b0; k_addra = 2'd0; k_dina = 64'h0; k_wea = 8'h00;
    a_enb = 1'b0; a_addrb = 2'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dout", a_doutb, 64'h0);

    // Bias only on output 0 (byte enables select the bias field only).
    wb_wr(3'd3, 64'h0800_1234_5678_9ABC, 8'hC0);
    k_wr(2'd0, 64'h1111_2222_3333_4444, 8'hFF);
    run("t1", 0, lat);
    check("t1_latency", 64'(lat), 64'd24);
    check_rows("t1", 64'h800, 64'h800, 64'h800, 64'h800);

    // Identity path to y0, y1 = 2*h0 - 1.
    wb_wr(3'd0, 64'h0000_0000_0000_1000, 8'hFF);
    wb_wr(3'd3, 64'h0000_0000_0000_1000, 8'hFF);
    wb_wr(3'd4, 64'hF000_0000_0000_2000, 8'hFF);
    k_wr(2'd0, 64'h2000_2000_1400_1400, 8'hFF);
    run("t2", 0, lat);
    check("t2_latency", 64'(lat), 64'd24);
    check_rows("t2", 64'h1800_1400, 64'h1800_1400, 64'h3000_2000, 64'h3000_2000);
    a_addrb = 2'd0;
    tick();
    check("t2_dout_hold", a_doutb, 64'h3000_2000);

    // clr between runs empties A; the stalled run must refill it identically.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_rows("clr0", 64'h0, 64'h0, 64'h0, 64'h0);
    run("stall", 8, lat);
    check("stall_latency", 64'(lat), 64'd29);
    check_rows("stall", 64'h1800_1400, 64'h1800_1400, 64'h3000_2000, 64'h3000_2000);

    // Negative hidden value clipped by ReLU; linear output keeps -1.0.
    wb_wr(3'd0, 64'h0000_0000_0000_F000, 8'hFF);
    k_wr(2'd0, 64'h2000_2000_2000_2000, 8'hFF);
    run("t3", 0, lat);
    check("t3_latency", 64'(lat), 64'd24);
    check_rows("t3", 64'hF000_0000, 64'hF000_0000, 64'hF000_0000, 64'hF000_0000);

    // Overflowing hidden neuron: clamp or wrap-then-ReLU.
    wb_wr(3'd0, 64'h0000_0000_0000_7FFF, 8'hFF);
    k_wr(2'd0, 64'h7FFF_7FFF_7FFF_7FFF, 8'hFF);
`ifdef NN_SATURATE_EN
    exp_t4 = 64'h7FFF_7FFF;
`else
    exp_t4 = 64'hF000_0000;
`endif
    run("t4", 0, lat);
    check_rows("t4", exp_t4, exp_t4, exp_t4, exp_t4);

    // start ignored while en is low.
    en = 1'b0; start = 1'b1;
    tick(); tick();
    check("en_low_start_ignored", {63'd0, ready}, 64'd1);
    start = 1'b0; en = 1'b1;
    tick();
    check("en_low_no_done", {63'd0, done}, 64'd0);

    // clr mid-run (with a simultaneous start) aborts without done and zeroes A.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    check("clr_ready", {63'd0, ready}, 64'd1);
    check("clr_done", {63'd0, done}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    check("clr_no_done", 64'(dcount), 64'd0);
    check_rows("clr", 64'h0, 64'h0, 64'h0, 64'h0);

    // rst mid-run restores reset state, including WB contents and the read register.
    run("t5", 0, lat);
    a_rd(2'd1, rd);
    check("t5_a1", rd, exp_t4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_ready", {63'd0, ready}, 64'd1);
    check("rst2_done", {63'd0, done}, 64'd0);
    check("rst2_dout", a_doutb, 64'h0);
    run("t6", 0, lat);
    check("t6_latency", 64'(lat), 64'd24);
    check_rows("t6", 64'h0, 64'h0, 64'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
